// File: rtl/dm_load_unit.sv
// rtl/dm_load_unit.sv - data-memory load unit: word fetch, byte/half extraction, sign/zero extension
// Optional feature macro: DM_LOAD_MISALIGNED_SPLIT_EN (serve word-crossing loads as two reads)
module dm_load_unit #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DM_ADDRESS-1:0] addr,
  input  logic [2:0]            funct3,
  output logic                  mem_re,
  output logic [31:0]           mem_raddr,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_data,
  output logic                  rsp_err
);

  localparam logic [2:0] F_LB  = 3'b000;
  localparam logic [2:0] F_LH  = 3'b001;
  localparam logic [2:0] F_LW  = 3'b010;
  localparam logic [2:0] F_LBU = 3'b100;
  localparam logic [2:0] F_LHU = 3'b101;
  localparam int         WIDX_W = DM_ADDRESS - 2;

  typedef enum logic [2:0] {IDLE, ISSUE0, CAP0, CAP1, RESP} state_t;

  state_t                  state, state_nxt;
  logic [DM_ADDRESS-1:0]   addr_q;
  logic [2:0]              funct3_q;
  logic                    cross_q;
  logic [DATA_W-1:0]       word0_q;

  logic                    accept;
  logic                    is_half, is_word, f3_ok;
  logic                    misalign_reject;
  logic                    req_legal, req_cross;
  logic [WIDX_W-1:0]       widx, widx_next;
  logic [DATA_W-1:0]       lo_word, hi_word, shifted, ext_data;
  logic [2*DATA_W-1:0]     pair;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;

  assign is_half = (funct3 == F_LH) || (funct3 == F_LHU);
  assign is_word = (funct3 == F_LW);
  assign f3_ok   = is_half || is_word || (funct3 == F_LB) || (funct3 == F_LBU);

`ifdef DM_LOAD_MISALIGNED_SPLIT_EN
  assign misalign_reject = 1'b0;
`else
  // Without split support any access not contained in one naturally aligned unit is refused
  assign misalign_reject = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
`endif

  assign req_legal = f3_ok && !misalign_reject;
  // Crossing only ever becomes true for accepted requests when split support is present,
  // because the refused misaligned cases are a superset of the crossing ones
  assign req_cross = (is_half && (addr[1:0] == 2'b11)) || (is_word && (addr[1:0] != 2'b00));

  assign widx      = addr_q[DM_ADDRESS-1:2];
  assign widx_next = widx + WIDX_W'(1);

  // Low word comes straight off the memory in CAP0; in CAP1 it is the saved first word
  assign lo_word = (state == CAP1) ? word0_q   : mem_rdata;
  assign hi_word = (state == CAP1) ? mem_rdata : '0;
  assign pair    = {hi_word, lo_word};
  assign shifted = DATA_W'(pair >> {addr_q[1:0], 3'b000});

  // Width extension of the extracted bytes according to the load type
  always_comb begin
    ext_data = shifted;
    case (funct3_q)
      F_LB:    ext_data = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
      F_LH:    ext_data = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
      F_LBU:   ext_data = {{(DATA_W-8){1'b0}}, shifted[7:0]};
      F_LHU:   ext_data = {{(DATA_W-16){1'b0}}, shifted[15:0]};
      default: ext_data = shifted;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and memory read strobe/address
  always_comb begin
    state_nxt = state;
    mem_re    = 1'b0;
    mem_raddr = '0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = req_legal ? ISSUE0 : RESP;
      end
      ISSUE0: begin
        mem_re    = 1'b1;
        mem_raddr = 32'({widx, 2'b00});
        state_nxt = CAP0;
      end
      CAP0: begin
        if (cross_q) begin
          mem_re    = 1'b1;
          mem_raddr = 32'({widx_next, 2'b00});
          state_nxt = CAP1;
        end else begin
          state_nxt = RESP;
        end
      end
      CAP1:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, word capture and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      funct3_q <= '0;
      cross_q  <= 1'b0;
      word0_q  <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q   <= addr;
            funct3_q <= funct3;
            cross_q  <= req_cross;
            rsp_err  <= !req_legal;
            rsp_data <= '0;
          end
        end
        CAP0: begin
          word0_q <= mem_rdata;
          if (!cross_q) rsp_data <= ext_data;
        end
        CAP1:    rsp_data <= ext_data;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_load_unit.sv
// tb/tb_dm_load_unit.sv - directed self-checking bench for dm_load_unit
module tb_dm_load_unit;

  localparam logic [2:0] F_LB  = 3'b000;
  localparam logic [2:0] F_LH  = 3'b001;
  localparam logic [2:0] F_LW  = 3'b010;
  localparam logic [2:0] F_LBU = 3'b100;
  localparam logic [2:0] F_LHU = 3'b101;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [8:0]  addr = '0;
  logic [2:0]  funct3 = '0;
  logic        mem_re;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic        rsp_err;

  logic [31:0] mem [0:127];
  int          rd_total = 0;
  logic [31:0] rd_prev = '0;
  logic [31:0] rd_last = '0;

  int n_checks = 0;
  int n_fail   = 0;

  dm_load_unit #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .addr      (addr),
    .funct3    (funct3),
    .mem_re    (mem_re),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  // Synchronous memory: data appears the cycle after the read strobe
  always @(posedge clk) if (mem_re) mem_rdata <= mem[mem_raddr[8:2]];

  // Read-strobe log, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n && mem_re) begin
      rd_prev  <= rd_last;
      rd_last  <= mem_raddr;
      rd_total <= rd_total + 1;
    end
  end

  // Presents one request at a negedge and waits for rsp_valid; latency counts the accept cycle as 1
  task automatic do_load(input logic [8:0] a, input logic [2:0] f,
                         output logic [31:0] d, output logic e, output int lat,
                         output int nrd, output logic [31:0] ra0, output logic [31:0] ra1);
    int base;
    base      = rd_total;
    addr      = a;
    funct3    = f;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    d   = rsp_data;
    e   = rsp_err;
    nrd = rd_total - base;
    ra0 = (nrd >= 2) ? rd_prev : rd_last;
    ra1 = rd_last;
  endtask

  task automatic finish_rsp;
    rsp_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_rsp_valid got %0b want 0", rsp_valid); end
    n_checks++; if (rsp_err !== 1'b0)    begin n_fail++; $display("FAIL reset_rsp_err got %0b want 0", rsp_err); end
    n_checks++; if (rsp_data !== 32'h0)  begin n_fail++; $display("FAIL reset_rsp_data got %h want 0", rsp_data); end
    n_checks++; if (mem_re !== 1'b0)     begin n_fail++; $display("FAIL reset_mem_re got %0b want 0", mem_re); end
    n_checks++; if (mem_raddr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_raddr got %h want 0", mem_raddr); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_req_ready got %0b want 1", req_ready); end
  endtask

  task automatic test_lb;
    logic [31:0] d, ra0, ra1; logic e; int lat, nrd;
    do_load(9'h010, F_LB, d, e, lat, nrd, ra0, ra1);
    n_checks++; if (d !== 32'hFFFF_FFF0) begin n_fail++; $display("FAIL lb_data got %h want fffffff0", d); end
    n_checks++; if (e !== 1'b0)          begin n_fail++; $display("FAIL lb_err got %0b want 0", e); end
    n_checks++; if (lat !== 3)           begin n_fail++; $display("FAIL lb_latency got %0d want 3", lat); end
    n_checks++; if (nrd !== 1)           begin n_fail++; $display("FAIL lb_reads got %0d want 1", nrd); end
    n_checks++; if (ra0 !== 32'h010)     begin n_fail++; $display("FAIL lb_raddr got %h want 00000010", ra0); end
    finish_rsp();
  endtask

  task automatic test_extend;
    logic [8:0]  va [7];
    logic [2:0]  vf [7];
    logic [31:0] vd [7];
    logic [31:0] d, ra0, ra1; logic e; int lat, nrd;
    va = '{9'h012, 9'h012, 9'h013, 9'h011, 9'h010, 9'h010, 9'h011};
    vf = '{F_LHU, F_LH, F_LBU, F_LB, F_LW, F_LH, F_LBU};
    vd = '{32'h0000_8877, 32'hFFFF_8877, 32'h0000_0088, 32'h0000_0066,
           32'h8877_66F0, 32'h0000_66F0, 32'h0000_0066};
    for (int i = 0; i < 7; i++) begin
      do_load(va[i], vf[i], d, e, lat, nrd, ra0, ra1);
      n_checks++; if (d !== vd[i]) begin n_fail++; $display("FAIL extend_data[%0d] got %h want %h", i, d, vd[i]); end
      n_checks++; if (e !== 1'b0)  begin n_fail++; $display("FAIL extend_err[%0d] got %0b want 0", i, e); end
      n_checks++; if (lat !== 3)   begin n_fail++; $display("FAIL extend_latency[%0d] got %0d want 3", i, lat); end
      finish_rsp();
    end
  endtask

  task automatic test_misaligned;
    logic [31:0] d, ra0, ra1; logic e; int lat, nrd;
`ifdef DM_LOAD_MISALIGNED_SPLIT_EN
    do_load(9'h1FE, F_LW, d, e, lat, nrd, ra0, ra1);
    n_checks++; if (d !== 32'h6655_4433) begin n_fail++; $display("FAIL cross_lw_data got %h want 66554433", d); end
    n_checks++; if (e !== 1'b0)          begin n_fail++; $display("FAIL cross_lw_err got %0b want 0", e); end
    n_checks++; if (lat !== 4)           begin n_fail++; $display("FAIL cross_lw_latency got %0d want 4", lat); end
    n_checks++; if (nrd !== 2)           begin n_fail++; $display("FAIL cross_lw_reads got %0d want 2", nrd); end
    n_checks++; if (ra0 !== 32'h1FC)     begin n_fail++; $display("FAIL cross_lw_raddr0 got %h want 000001fc", ra0); end
    n_checks++; if (ra1 !== 32'h000)     begin n_fail++; $display("FAIL cross_lw_raddr1 got %h want 00000000", ra1); end
    finish_rsp();
    do_load(9'h013, F_LH, d, e, lat, nrd, ra0, ra1);
    n_checks++; if (d !== 32'hFFFF_AB88) begin n_fail++; $display("FAIL cross_lh_data got %h want ffffab88", d); end
    n_checks++; if (lat !== 4)           begin n_fail++; $display("FAIL cross_lh_latency got %0d want 4", lat); end
    finish_rsp();
    do_load(9'h011, F_LH, d, e, lat, nrd, ra0, ra1);
    n_checks++; if (d !== 32'h0000_7766) begin n_fail++; $display("FAIL mis_lh_data got %h want 00007766", d); end
    n_checks++; if (nrd !== 1)           begin n_fail++; $display("FAIL mis_lh_reads got %0d want 1", nrd); end
    finish_rsp();
`else
    do_load(9'h1FE, F_LW, d, e, lat, nrd, ra0, ra1);
    n_checks++; if (d !== 32'h0)  begin n_fail++; $display("FAIL mis_lw_data got %h want 0", d); end
    n_checks++; if (e !== 1'b1)   begin n_fail++; $display("FAIL mis_lw_err got %0b want 1", e); end
    n_checks++; if (nrd !== 0)    begin n_fail++; $display("FAIL mis_lw_reads got %0d want 0", nrd); end
    n_checks++; if (lat !== 1)    begin n_fail++; $display("FAIL mis_lw_latency got %0d want 1", lat); end
    finish_rsp();
    do_load(9'h011, F_LH, d, e, lat, nrd, ra0, ra1);
    n_checks++; if (e !== 1'b1)   begin n_fail++; $display("FAIL mis_lh_err got %0b want 1", e); end
    n_checks++; if (nrd !== 0)    begin n_fail++; $display("FAIL mis_lh_reads got %0d want 0", nrd); end
    finish_rsp();
    do_load(9'h013, F_LHU, d, e, lat, nrd, ra0, ra1);
    n_checks++; if (e !== 1'b1)   begin n_fail++; $display("FAIL mis_lhu_err got %0b want 1", e); end
    n_checks++; if (d !== 32'h0)  begin n_fail++; $display("FAIL mis_lhu_data got %h want 0", d); end
    finish_rsp();
`endif
  endtask

  task automatic test_illegal;
    logic [2:0]  vf [3];
    logic [8:0]  va [3];
    logic [31:0] d, ra0, ra1; logic e; int lat, nrd;
    vf = '{3'b011, 3'b110, 3'b111};
    va = '{9'h010, 9'h1FF, 9'h000};
    for (int i = 0; i < 3; i++) begin
      rsp_ready = 1'b0;
      do_load(va[i], vf[i], d, e, lat, nrd, ra0, ra1);
      n_checks++; if (e !== 1'b1)  begin n_fail++; $display("FAIL illegal_err[%0d] got %0b want 1", i, e); end
      n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL illegal_data[%0d] got %h want 0", i, d); end
      n_checks++; if (nrd !== 0)   begin n_fail++; $display("FAIL illegal_reads[%0d] got %0d want 0", i, nrd); end
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b1)  begin n_fail++; $display("FAIL hold_valid[%0d/%0d] got %0b want 1", i, c, rsp_valid); end
        n_checks++; if (rsp_err !== 1'b1)    begin n_fail++; $display("FAIL hold_err[%0d/%0d] got %0b want 1", i, c, rsp_err); end
        n_checks++; if (rsp_data !== 32'h0)  begin n_fail++; $display("FAIL hold_data[%0d/%0d] got %h want 0", i, c, rsp_data); end
        n_checks++; if (req_ready !== 1'b0)  begin n_fail++; $display("FAIL hold_req_ready[%0d/%0d] got %0b want 0", i, c, req_ready); end
      end
      finish_rsp();
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL illegal_drain[%0d] got %0b want 0", i, rsp_valid); end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d, ra0, ra1; logic e; int lat, nrd;
    do_load(9'h010, 3'b111, d, e, lat, nrd, ra0, ra1);
    finish_rsp();
    do_load(9'h1FD, F_LBU, d, e, lat, nrd, ra0, ra1);
    n_checks++; if (d !== 32'h0000_0022) begin n_fail++; $display("FAIL b2b_lbu_data got %h want 00000022", d); end
    n_checks++; if (e !== 1'b0)          begin n_fail++; $display("FAIL b2b_lbu_err got %0b want 0", e); end
    n_checks++; if (ra0 !== 32'h1FC)     begin n_fail++; $display("FAIL b2b_lbu_raddr got %h want 000001fc", ra0); end
    finish_rsp();
    do_load(9'h000, F_LW, d, e, lat, nrd, ra0, ra1);
    n_checks++; if (d !== 32'h8877_6655) begin n_fail++; $display("FAIL b2b_lw_data got %h want 88776655", d); end
    finish_rsp();
  endtask

  task automatic test_reset_mid;
    logic [31:0] d, ra0, ra1; logic e; int lat, nrd;
    int seen;
`ifdef DM_LOAD_MISALIGNED_SPLIT_EN
    addr = 9'h1FE;
`else
    addr = 9'h010;
`endif
    funct3    = F_LW;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_rsp_valid got %0b want 0", rsp_valid); end
    n_checks++; if (mem_re !== 1'b0)    begin n_fail++; $display("FAIL midrst_mem_re got %0b want 0", mem_re); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_req_ready got %0b want 1", req_ready); end
    n_checks++; if (rsp_data !== 32'h0) begin n_fail++; $display("FAIL midrst_rsp_data got %h want 0", rsp_data); end
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (rsp_valid === 1'b1 || mem_re === 1'b1) seen++;
      @(negedge clk);
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL midrst_no_response got %0d active cycles want 0", seen); end
    do_load(9'h010, F_LB, d, e, lat, nrd, ra0, ra1);
    n_checks++; if (d !== 32'hFFFF_FFF0) begin n_fail++; $display("FAIL midrst_after_data got %h want fffffff0", d); end
    finish_rsp();
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    mem[4]   = 32'h8877_66F0;
    mem[5]   = 32'h0000_00AB;
    mem[127] = 32'h4433_2211;
    mem[0]   = 32'h8877_6655;
    test_reset();
    test_lb();
    test_extend();
    test_misaligned();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
